sram_port_arb: RTL and testbench

SRAM_PORT_ARB -- requirements
Module: sram_port_arb

---
 rtl/sram_port_arb_pkg.sv | 31 +++
 rtl/sram_port_arb_rr_pick.sv | 40 ++++
 rtl/sram_port_arb.sv | 156 +++++++++++++++
 tb/tb_sram_port_arb.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arb_pkg
// Description : Shared definitions for the SRAM port arbiter: FSM state
//               encoding, lock timeout length and the clogb2 width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_port_arb_pkg;

    // Consecutive idle cycles of a lock owner before its lock is dropped.
    localparam int c_LOCK_TIMEOUT = 16;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,   // round-robin arbitration among all requesters
        ST_LOCKED = 1'b1    // only the lock owner may be granted
    } arb_state_t;

    // Number of bits needed to hold 'value' (at least 1).
    function automatic int clogb2(input int value);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if ((value >> i) != 0) begin
                n = i + 1;
            end
        end
        return (n == 0) ? 1 : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_port_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arb_rr_pick
// Description : Combinational round-robin priority encoder. The search starts
//               one position after i_ptr and wraps; the first asserted request
//               wins.
// Ports       : i_req   - request vector
//               i_ptr   - index of the last winner
//               o_grant - one-hot grant (all zero when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arb_rr_pick
    import sram_port_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant
);

    logic        w_found;
    logic [31:0] w_idx;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (32'(i_ptr) + 32'(k)) % 32'(NREQ);
            if (!w_found && i_req[w_idx[PW-1:0]]) begin
                o_grant[w_idx[PW-1:0]] = 1'b1;
                w_found                = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arb
// Description : Round-robin arbiter sharing one 32-bit single-port RAM among
//               NREQ requesters, with optional grant locking and a lock
//               timeout. Grant is combinational, the response strobe follows
//               one cycle after each accepted beat.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               m_valid/m_ready  - per-requester request handshake
//               m_lock           - keep grant after this beat
//               m_we/m_wem/m_addr/m_wdata - per-requester beat payload
//               m_rsp_valid      - per-requester one-cycle response strobe
//               m_rdata          - shared read data (ram_dout)
//               ram_*            - RAM port (1-cycle registered read)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arb
    import sram_port_arb_pkg::*;
#(
    parameter  int NREQ      = 3,
    parameter  int RAM_DEPTH = 2048,
    localparam int AW        = clogb2(RAM_DEPTH - 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      m_valid,
    output logic [NREQ-1:0]      m_ready,
    input  logic [NREQ-1:0]      m_lock,
    input  logic [NREQ-1:0]      m_we,
    input  logic [4*NREQ-1:0]    m_wem,
    input  logic [AW*NREQ-1:0]   m_addr,
    input  logic [32*NREQ-1:0]   m_wdata,
    output logic [NREQ-1:0]      m_rsp_valid,
    output logic [31:0]          m_rdata,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [3:0]           ram_wem,
    output logic [AW-1:0]        ram_addr,
    output logic [31:0]          ram_din,
    input  logic [31:0]          ram_dout
);

    localparam int PW = (NREQ > 1) ? clogb2(NREQ - 1) : 1;
    localparam int TW = clogb2(c_LOCK_TIMEOUT - 1);

    arb_state_t      r_state;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_lock_owner;
    logic [TW-1:0]   r_to_cnt;
    logic [NREQ-1:0] r_rsp_valid;

    logic [NREQ-1:0] w_req_mask;
    logic [NREQ-1:0] w_req;
    logic [NREQ-1:0] w_grant;
    logic [NREQ-1:0] w_xfer;
    logic            w_any_xfer;
    logic [PW-1:0]   w_sel;

    // While locked, every requester except the owner is hidden from the picker.
    always_comb begin
        w_req_mask = '1;
        if (r_state == ST_LOCKED) begin
            for (int i = 0; i < NREQ; i++) begin
                w_req_mask[i] = (r_lock_owner == PW'(i));
            end
        end
    end

    assign w_req = m_valid & w_req_mask;

    sram_port_arb_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant)
    );

    assign m_ready    = rst ? '0 : w_grant;
    assign w_xfer     = m_valid & m_ready;
    assign w_any_xfer = |w_xfer;

    // RAM request mux; everything idles at zero when no beat is accepted.
    always_comb begin
        w_sel    = '0;
        ram_en   = w_any_xfer;
        ram_we   = 1'b0;
        ram_wem  = 4'b0000;
        ram_addr = '0;
        ram_din  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_xfer[i]) begin
                w_sel    = PW'(i);
                ram_we   = m_we[i];
                ram_wem  = m_we[i] ? m_wem[4*i +: 4] : 4'b0000;
                ram_addr = m_addr[AW*i +: AW];
                ram_din  = m_wdata[32*i +: 32];
            end
        end
    end

    // Response strobe is suppressed while reset is held so a beat accepted
    // just before reset never reports back.
    assign m_rsp_valid = rst ? '0 : r_rsp_valid;
    assign m_rdata     = ram_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= PW'(NREQ - 1);
            r_lock_owner <= '0;
            r_to_cnt     <= '0;
            r_rsp_valid  <= '0;
        end else begin
            r_rsp_valid <= w_xfer;
            if (w_any_xfer) begin
                r_rr_ptr <= w_sel;
            end

            unique case (r_state)
                ST_IDLE: begin
                    r_to_cnt <= '0;
                    if (w_any_xfer && m_lock[w_sel]) begin
                        r_state      <= ST_LOCKED;
                        r_lock_owner <= w_sel;
                    end
                end
                ST_LOCKED: begin
                    if (w_any_xfer) begin
                        // Only the owner can transfer here.
                        r_to_cnt <= '0;
                        if (!m_lock[w_sel]) begin
                            r_state <= ST_IDLE;
                        end
                    end else if (!m_valid[r_lock_owner]) begin
                        if (r_to_cnt == TW'(c_LOCK_TIMEOUT - 1)) begin
                            r_state  <= ST_IDLE;
                            r_to_cnt <= '0;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end else begin
                        r_to_cnt <= '0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_to_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_port_arb
// Description : Directed self-checking bench for sram_port_arb with a simple
//               behavioural RAM (byte-masked writes, 1-cycle registered read).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_arb;

    localparam int NREQ      = 3;
    localparam int RAM_DEPTH = 2048;
    localparam int AW        = 11;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     m_valid;
    logic [NREQ-1:0]     m_ready;
    logic [NREQ-1:0]     m_lock;
    logic [NREQ-1:0]     m_we;
    logic [4*NREQ-1:0]   m_wem;
    logic [AW*NREQ-1:0]  m_addr;
    logic [32*NREQ-1:0]  m_wdata;
    logic [NREQ-1:0]     m_rsp_valid;
    logic [31:0]         m_rdata;
    logic                ram_en;
    logic                ram_we;
    logic [3:0]          ram_wem;
    logic [AW-1:0]       ram_addr;
    logic [31:0]         ram_din;
    logic [31:0]         ram_dout = 32'h0;

    logic [31:0] mem [0:RAM_DEPTH-1] = '{16: 32'hDEADBEEF, default: 32'h0};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_port_arb #(
        .NREQ      (NREQ),
        .RAM_DEPTH (RAM_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_lock      (m_lock),
        .m_we        (m_we),
        .m_wem       (m_wem),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rsp_valid (m_rsp_valid),
        .m_rdata     (m_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_wem     (ram_wem),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    // Behavioural RAM
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
                end
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic [3:0] wem,
                           input logic [AW-1:0] addr, input logic [31:0] wd, input logic lk);
        m_valid[i]          = v;
        m_we[i]             = we;
        m_wem[4*i +: 4]     = wem;
        m_addr[AW*i +: AW]  = addr;
        m_wdata[32*i +: 32] = wd;
        m_lock[i]           = lk;
    endtask

    task automatic clr_all();
        m_valid = '0;
        m_lock  = '0;
        m_we    = '0;
        m_wem   = '0;
        m_addr  = '0;
        m_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] fair_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [2:0] lock_exp [5] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_all();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 4'h0, AW'(i), 32'h0, 1'b0);
        tick();
        tick();
        check("rst_ready",  32'(m_ready),     32'h0);
        check("rst_ram_en", 32'(ram_en),      32'h0);
        check("rst_rsp",    32'(m_rsp_valid), 32'h0);

        // Fairness from reset: all three valid continuously
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("fair_grant", 32'(m_ready), 32'(fair_exp[k]));
            tick();
            check("fair_rsp", 32'(m_rsp_valid), 32'(fair_exp[k]));
        end
        clr_all();
        tick();
        check("idle_rsp", 32'(m_rsp_valid), 32'h0);

        // Single read by requester 1; wem must be masked off on a read
        set_req(1, 1'b1, 1'b0, 4'hF, 11'h010, 32'h0, 1'b0);
        #1;
        check("rd_ready",   32'(m_ready),  32'h2);
        check("rd_ram_en",  32'(ram_en),   32'h1);
        check("rd_ram_adr", 32'(ram_addr), 32'h010);
        check("rd_ram_wem", 32'(ram_wem),  32'h0);
        tick();
        clr_all();
        check("rd_rsp",   32'(m_rsp_valid), 32'h2);
        check("rd_rdata", m_rdata,          32'hDEADBEEF);

        // Byte-masked write by requester 0, then read back
        set_req(0, 1'b1, 1'b1, 4'b0101, 11'h020, 32'h11223344, 1'b0);
        #1;
        check("wr_ready",   32'(m_ready), 32'h1);
        check("wr_ram_we",  32'(ram_we),  32'h1);
        check("wr_ram_wem", 32'(ram_wem), 32'h5);
        check("wr_ram_din", ram_din,      32'h11223344);
        tick();
        clr_all();
        check("wr_rsp", 32'(m_rsp_valid), 32'h1);
        set_req(0, 1'b1, 1'b0, 4'h0, 11'h020, 32'h0, 1'b0);
        tick();
        clr_all();
        check("wrrd_rsp",   32'(m_rsp_valid), 32'h1);
        check("wrrd_rdata", m_rdata,          32'h00220044);

        // Lock: requester 1 first so the pointer favours 2
        set_req(1, 1'b1, 1'b0, 4'h0, 11'h000, 32'h0, 1'b0);
        #1;
        check("lock_pre", 32'(m_ready), 32'h2);
        tick();
        for (int k = 0; k < 5; k++) begin
            set_req(0, 1'b1, 1'b0, 4'h0, 11'h001, 32'h0, 1'b0);
            set_req(1, 1'b1, 1'b0, 4'h0, 11'h002, 32'h0, 1'b0);
            set_req(2, (k < 4), 1'b0, 4'h0, 11'h003, 32'h0, (k < 3));
            #1;
            check("lock_grant", 32'(m_ready), 32'(lock_exp[k]));
            tick();
        end
        clr_all();
        tick();

        // Lock timeout: requester 1 locks, then goes quiet
        set_req(1, 1'b1, 1'b0, 4'h0, 11'h004, 32'h0, 1'b1);
        #1;
        check("to_lock", 32'(m_ready), 32'h2);
        tick();
        clr_all();
        set_req(0, 1'b1, 1'b0, 4'h0, 11'h005, 32'h0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            #1;
            check("to_block", 32'(m_ready), 32'h0);
            tick();
        end
        #1;
        check("to_release", 32'(m_ready), 32'h1);
        tick();
        clr_all();
        tick();

        // Reset one cycle after a read is accepted
        set_req(2, 1'b1, 1'b0, 4'h0, 11'h010, 32'h0, 1'b0);
        #1;
        check("rr_ready", 32'(m_ready), 32'h4);
        tick();
        rst = 1'b1;
        clr_all();
        #1;
        check("rr_rsp_in_rst", 32'(m_rsp_valid), 32'h0);
        check("rr_ram_en",     32'(ram_en),      32'h0);
        tick();
        check("rr_rsp_after", 32'(m_rsp_valid), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 4'h0, 11'h000, 32'h0, 1'b0);
        #1;
        check("rr_first", 32'(m_ready), 32'h1);
        tick();
        clr_all();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
